// File: rtl/spi_cfg_master_if.sv
// Requester-side bus for spi_cfg_master: per-requester valid/ready with packed address and data lanes.
interface spi_cfg_master_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [7*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/spi_cfg_master.sv
// Round-robin SPI mode-0 write master: sends 16-bit {1, addr[6:0], data[7:0]} frames, MSB first.
// Optional SPI_CFG_ADDR_CHECK_EN rejects addresses above MAX_ADDR with an err pulse instead of a frame.
module spi_cfg_master #(
  parameter int         N_REQ    = 2,
  parameter int         CLK_DIV  = 4,
  parameter int         CS_GAP   = 4,
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_cfg_master_if.slave     req_if,
  output logic                busy,
  output logic                done,
  output logic [1:0]          done_id,
  output logic                err,
  output logic                sclk,
  output logic                ncs,
  output logic                copi
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL, GAP} state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] frame_q, frame_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_id_q, done_id_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        copi_q, copi_d;

  logic [1:0]  gnt;
  logic        gnt_vld;
  int          arb_idx;
  logic [6:0]  gnt_addr;
  logic [7:0]  gnt_data;
  logic        accept;
  logic        bad_addr;
  logic        tick;

  // Scan from the highest offset down so the lowest offset from the pointer wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    arb_idx = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      arb_idx = int'(ptr_q) + off;
      if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
      if (req_if.req_valid[arb_idx]) begin
        gnt     = 2'(arb_idx);
        gnt_vld = 1'b1;
      end
    end
  end

  assign gnt_addr = req_if.req_addr[7*int'(gnt) +: 7];
  assign gnt_data = req_if.req_data[8*int'(gnt) +: 8];

  // busy_q gates ready for the single rejected-request cycle spent in IDLE.
  always_comb begin
    req_if.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_if.req_ready[i] = (state_q == IDLE) && !busy_q && gnt_vld && (int'(gnt) == i);
    end
  end

  assign accept = |req_if.req_ready;
  assign tick   = (div_q == 8'd0);

`ifdef SPI_CFG_ADDR_CHECK_EN
  assign bad_addr = (gnt_addr > MAX_ADDR);
`else
  assign bad_addr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q - 8'd1;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    done_id_d = done_id_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    copi_d    = copi_q;

    case (state_q)
      IDLE: begin
        div_d  = div_q;
        busy_d = 1'b0;
        if (accept) begin
          ptr_d   = (int'(gnt) == N_REQ - 1) ? 2'd0 : gnt + 2'd1;
          grant_d = gnt;
          busy_d  = 1'b1;
          if (bad_addr) begin
            err_d     = 1'b1;
            done_id_d = gnt;
          end else begin
            frame_d   = {1'b1, gnt_addr, gnt_data};
            state_d   = LEAD;
            div_d     = DIV_RELOAD;
            bit_cnt_d = 5'd0;
            ncs_d     = 1'b0;
            sclk_d    = 1'b0;
            copi_d    = 1'b1;
          end
        end
      end
      LEAD: begin
        if (tick) begin
          state_d   = SHIFT_HI;
          div_d     = DIV_RELOAD;
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          state_d = SHIFT_LO;
          div_d   = DIV_RELOAD;
          sclk_d  = 1'b0;
          copi_d  = frame_q[14];
          frame_d = {frame_q[14:0], 1'b0};
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          div_d = DIV_RELOAD;
          if (bit_cnt_q == 5'd16) begin
            state_d = TRAIL;
          end else begin
            state_d   = SHIFT_HI;
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d   = GAP;
          div_d     = GAP_RELOAD;
          ncs_d     = 1'b1;
          copi_d    = 1'b0;
          done_d    = 1'b1;
          done_id_d = grant_q;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          div_d   = DIV_RELOAD;
          busy_d  = 1'b0;
          copi_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= DIV_RELOAD;
      bit_cnt_q <= 5'd0;
      frame_q   <= 16'd0;
      ptr_q     <= 2'd0;
      grant_q   <= 2'd0;
      done_id_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;
  assign sclk    = sclk_q;
  assign ncs     = ncs_q;
  assign copi    = copi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: DUT 0 at CLK_DIV=4, DUT 1 at CLK_DIV=2, both with two requesters.
module tb_spi_cfg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0][1:0]  vld;
  logic [1:0][13:0] adr;
  logic [1:0][15:0] dat;
  logic [1:0][1:0]  rdy;
  logic [1:0]       busy_w, done_w, err_w, sclk_w, ncs_w, copi_w;
  logic [1:0][1:0]  did_w;

  spi_cfg_master_if #(.N_REQ(2)) if0 ();
  spi_cfg_master_if #(.N_REQ(2)) if1 ();

  assign if0.req_valid = vld[0];
  assign if0.req_addr  = adr[0];
  assign if0.req_data  = dat[0];
  assign rdy[0]        = if0.req_ready;
  assign if1.req_valid = vld[1];
  assign if1.req_addr  = adr[1];
  assign if1.req_data  = dat[1];
  assign rdy[1]        = if1.req_ready;

  spi_cfg_master #(.N_REQ(2), .CLK_DIV(4), .CS_GAP(4), .MAX_ADDR(7'h04)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_if(if0.slave),
    .busy(busy_w[0]), .done(done_w[0]), .done_id(did_w[0]), .err(err_w[0]),
    .sclk(sclk_w[0]), .ncs(ncs_w[0]), .copi(copi_w[0])
  );

  spi_cfg_master #(.N_REQ(2), .CLK_DIV(2), .CS_GAP(4), .MAX_ADDR(7'h04)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_if(if1.slave),
    .busy(busy_w[1]), .done(done_w[1]), .done_id(did_w[1]), .err(err_w[1]),
    .sclk(sclk_w[1]), .ncs(ncs_w[1]), .copi(copi_w[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int min);
    n_chk++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d", nm, act, min);
    end
  endtask

  // Bus monitor: frame capture on sclk rises, ncs run lengths, copi setup/hold around rises.
  int          rises[2], low[2], high_run[2], last_rises[2], last_low[2];
  int          since_chg[2], since_rise[2], min_setup[2], min_hold[2], gap_min[2];
  int          done_cnt[2], err_cnt[2], idle_bad[2];
  bit          have_frame[2];
  logic [15:0] rx[2], last_frame[2];
  logic        prev_ncs[2], prev_sclk[2], prev_copi[2];
  logic [1:0]  id_log[$];
  logic [15:0] frm_log[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_ncs[k] = 1'b1; prev_sclk[k] = 1'b0; prev_copi[k] = 1'b0;
      rises[k] = 0; low[k] = 0; high_run[k] = 0; rx[k] = '0;
      since_chg[k] = 9999; since_rise[k] = 9999;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (since_chg[k] < 9999) since_chg[k]++;
        if (since_rise[k] < 9999) since_rise[k]++;
        if (!ncs_w[k] && prev_ncs[k]) begin
          if (have_frame[k] && high_run[k] < gap_min[k]) gap_min[k] = high_run[k];
          rx[k] = '0; rises[k] = 0; low[k] = 0; since_rise[k] = 9999;
        end
        if (ncs_w[k] && !prev_ncs[k]) begin
          last_frame[k] = rx[k]; last_rises[k] = rises[k]; last_low[k] = low[k];
          have_frame[k] = 1'b1; high_run[k] = 0;
        end
        if (ncs_w[k]) high_run[k]++;
        else          low[k]++;
        if (sclk_w[k] && !prev_sclk[k]) begin
          if (ncs_w[k]) idle_bad[k]++;
          else begin
            rx[k] = {rx[k][14:0], copi_w[k]};
            rises[k]++;
            if (since_chg[k] < min_setup[k]) min_setup[k] = since_chg[k];
            since_rise[k] = 0;
          end
        end
        if (copi_w[k] != prev_copi[k]) begin
          if (!ncs_w[k] && since_rise[k] < min_hold[k]) min_hold[k] = since_rise[k];
          since_chg[k] = 0;
        end
        if (done_w[k]) begin
          done_cnt[k]++;
          if (k == 0) begin
            id_log.push_back(did_w[0]);
            frm_log.push_back(rx[0]);
          end
        end
        if (err_w[k]) err_cnt[k]++;
        prev_ncs[k] = ncs_w[k]; prev_sclk[k] = sclk_w[k]; prev_copi[k] = copi_w[k];
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0; err_cnt[k] = 0; idle_bad[k] = 0;
      min_setup[k] = 9999; min_hold[k] = 9999; gap_min[k] = 9999;
      have_frame[k] = 1'b0; last_frame[k] = '0; last_rises[k] = 0; last_low[k] = 0;
    end
    id_log.delete();
    frm_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (!done_w[k] && n < 2000) begin @(negedge clk); n++; end
    if (!done_w[k]) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_w[k] && n < 200) begin @(negedge clk); n++; end
    if (busy_w[k]) chk("idle_timeout", 0, 1);
  endtask

  // lat counts clk cycles from the accept cycle (0) to the done cycle.
  task automatic do_write(input int k, input int r, input logic [6:0] a, input logic [7:0] d,
                          output int lat);
    int n;
    lat = -1;
    @(negedge clk);
    adr[k][7*r +: 7] = a;
    dat[k][8*r +: 8] = d;
    vld[k][r] = 1'b1;
    #1;
    n = 0;
    while (!rdy[k][r] && n < 300) begin @(negedge clk); #1; n++; end
    if (!rdy[k][r]) begin
      chk("ready_timeout", 0, 1);
      vld[k][r] = 1'b0;
      return;
    end
    lat = 0;
    n = 0;
    do begin
      @(negedge clk);
      lat++;
      vld[k][r] = 1'b0;
      n++;
    end while (!done_w[k] && n < 2000);
    if (!done_w[k]) begin chk("done_timeout", 0, 1); lat = -1; end
    @(posedge clk); #1;
    wait_idle(k);
  endtask

  typedef struct {
    int          k;
    int          r;
    logic [6:0]  a;
    logic [7:0]  d;
    int          div;
    logic [15:0] frame;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, viol;

    vt[0] = '{0, 0, 7'h02, 8'hA5, 4, 16'h82A5};
    vt[1] = '{0, 1, 7'h03, 8'h3C, 4, 16'h833C};
    vt[2] = '{1, 0, 7'h04, 8'hFF, 2, 16'h84FF};
    vt[3] = '{1, 1, 7'h00, 8'h00, 2, 16'h8000};
    vt[4] = '{0, 1, 7'h01, 8'hC3, 4, 16'h81C3};

    rst_n = 1'b0;
    vld = '0; adr = '0; dat = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ncs%0d", k),  ncs_w[k], 1);
      chk($sformatf("rst_sclk%0d", k), sclk_w[k], 0);
      chk($sformatf("rst_copi%0d", k), copi_w[k], 0);
      chk($sformatf("rst_busy%0d", k), busy_w[k], 0);
      chk($sformatf("rst_done%0d", k), done_w[k], 0);
      chk($sformatf("rst_err%0d", k),  err_w[k], 0);
      chk($sformatf("rst_did%0d", k),  did_w[k], 0);
      chk($sformatf("rst_rdy%0d", k),  rdy[k], 0);
    end
    rst_n = 1'b1;

    // Single frames through the table.
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      do_write(vt[i].k, vt[i].r, vt[i].a, vt[i].d, lat);
      chk($sformatf("v%0d_latency", i), lat, vt[i].div * 34 + 1);
      chk($sformatf("v%0d_ncs_low", i), last_low[vt[i].k], vt[i].div * 34);
      chk($sformatf("v%0d_frame", i), last_frame[vt[i].k], vt[i].frame);
      chk($sformatf("v%0d_rises", i), last_rises[vt[i].k], 16);
      chk($sformatf("v%0d_done_cnt", i), done_cnt[vt[i].k], 1);
      chk($sformatf("v%0d_done_id", i), did_w[vt[i].k], vt[i].r);
      chk($sformatf("v%0d_idle_sclk", i), idle_bad[vt[i].k], 0);
      chk_ge($sformatf("v%0d_setup", i), min_setup[vt[i].k], vt[i].div);
      chk_ge($sformatf("v%0d_hold", i), min_hold[vt[i].k], vt[i].div);
      chk($sformatf("v%0d_busy_after", i), busy_w[vt[i].k], 0);
    end

    // Both requesters valid continuously: grants alternate, frames separated by the gap.
    do_reset();
    clear_mon();
    @(negedge clk);
    adr[0] = {7'd1, 7'd0};
    dat[0] = {8'h22, 8'h11};
    vld[0] = 2'b11;
    n = 0;
    while (id_log.size() < 4 && n < 3000) begin @(negedge clk); n++; end
    vld[0] = 2'b00;
    wait_idle(0);
    chk_ge("rr_frames", id_log.size(), 4);
    for (int i = 0; i < 4 && i < id_log.size(); i++) begin
      chk($sformatf("rr_id%0d", i), id_log[i], i % 2);
      chk($sformatf("rr_frame%0d", i), frm_log[i], (i % 2) ? 16'h8122 : 16'h8011);
    end
    chk_ge("rr_gap", gap_min[0], 4);
    chk("rr_idle_sclk", idle_bad[0], 0);

    // Request arriving while busy waits for IDLE; accepted data is not affected by later edits.
    do_reset();
    clear_mon();
    @(negedge clk);
    adr[0][6:0] = 7'h02;
    dat[0][7:0] = 8'h77;
    vld[0][0]   = 1'b1;
    #1;
    chk("busy_first_rdy", rdy[0], 2'b01);
    @(negedge clk);
    vld[0][0]    = 1'b0;
    adr[0][13:7] = 7'h03;
    dat[0][15:8] = 8'h5A;
    vld[0][1]    = 1'b1;
    #1;
    viol = 0;
    n = 0;
    while (busy_w[0] && n < 400) begin
      if (rdy[0][1]) viol++;
      @(negedge clk); #1;
      n++;
    end
    chk("busy_rdy_held_low", viol, 0);
    chk("busy_first_idle_rdy", rdy[0], 2'b10);
    @(negedge clk);
    vld[0][1]    = 1'b0;
    adr[0][13:7] = 7'h00;
    dat[0][15:8] = 8'h00;
    wait_done(0);
    chk("busy_frame", last_frame[0], 16'h835A);
    chk("busy_done_id", did_w[0], 1);
    wait_idle(0);

    // Reset on the 8th rising sclk, then a clean frame with requester 0 preferred.
    do_reset();
    clear_mon();
    @(negedge clk);
    adr[0][6:0] = 7'h02;
    dat[0][7:0] = 8'hA5;
    vld[0][0]   = 1'b1;
    @(negedge clk);
    vld[0][0] = 1'b0;
    #1;
    n = 0;
    while (rises[0] < 8 && n < 500) begin @(negedge clk); #1; n++; end
    chk("mid_rise8", rises[0], 8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ncs", ncs_w[0], 1);
    chk("mid_rst_sclk", sclk_w[0], 0);
    chk("mid_rst_busy", busy_w[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    adr[0] = {7'h01, 7'h03};
    dat[0] = {8'hBB, 8'hAA};
    vld[0] = 2'b11;
    #1;
    chk("mid_prio_rdy", rdy[0], 2'b01);
    @(negedge clk);
    vld[0] = 2'b00;
    wait_done(0);
    chk("mid_frame", last_frame[0], 16'h83AA);
    chk("mid_rises", last_rises[0], 16);
    chk("mid_done_id", did_w[0], 0);
    wait_idle(0);

`ifdef SPI_CFG_ADDR_CHECK_EN
    clear_mon();
    @(negedge clk);
    adr[0][13:7] = 7'h05;
    dat[0][15:8] = 8'h12;
    vld[0][1]    = 1'b1;
    #1;
    chk("chk_rdy", rdy[0], 2'b10);
    @(negedge clk);
    vld[0][1] = 1'b0;
    chk("chk_err", err_w[0], 1);
    chk("chk_done", done_w[0], 0);
    chk("chk_did", did_w[0], 1);
    chk("chk_busy", busy_w[0], 1);
    chk("chk_ncs", ncs_w[0], 1);
    @(negedge clk);
    chk("chk_err_drop", err_w[0], 0);
    chk("chk_busy_drop", busy_w[0], 0);
    chk("chk_ncs_idle", ncs_w[0], 1);
    do_write(0, 0, 7'h04, 8'h5C, lat);
    chk("chk_next_lat", lat, 137);
    chk("chk_next_frame", last_frame[0], 16'h845C);
    chk("chk_err_cnt", err_cnt[0], 1);
`else
    clear_mon();
    do_write(0, 1, 7'h05, 8'h12, lat);
    chk("addr5_lat", lat, 137);
    chk("addr5_frame", last_frame[0], 16'h8512);
    chk("addr5_did", did_w[0], 1);
    chk("addr5_err_cnt", err_cnt[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
